// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, request sources and memory ops.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// Combinational winner selection between two requesters; reusable for other two-port arbiters.
module arb_pick
    import arbiter_types::*;
#(
    parameter int FAIR = 1
) (
    input  logic     i_req_i,
    input  logic     d_req_i,
    input  arb_src_t last_grant_i,
    output logic     grant_valid_o,
    output arb_src_t grant_src_o
);

    // Fair mode hands contention to whoever was not served last; otherwise D wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_src_o   = SRC_I;
        if (i_req_i && d_req_i) begin
            grant_valid_o = 1'b1;
            if (FAIR != 0) begin
                grant_src_o = (last_grant_i == SRC_I) ? SRC_D : SRC_I;
            end else begin
                grant_src_o = SRC_D;
            end
        end else if (d_req_i) begin
            grant_valid_o = 1'b1;
            grant_src_o   = SRC_D;
        end else if (i_req_i) begin
            grant_valid_o = 1'b1;
            grant_src_o   = SRC_I;
        end else begin
            grant_valid_o = 1'b0;
            grant_src_o   = SRC_I;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single line-wide memory port between the i-cache and d-cache.
// One transaction at a time: grant, forward latched request, register the line, pulse the winner.
module cache_mem_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5,
    parameter int FAIR     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t        state_q, state_d;
    arb_src_t          last_q,  last_d;
    arb_src_t          src_q,   src_d;
    arb_op_t           op_q,    op_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q,  line_d;

    logic     grant_valid_s;
    arb_src_t grant_src_s;
    logic     busy_s;

    arb_pick #(
        .FAIR (FAIR)
    ) u_pick (
        .i_req_i       (i_read),
        .d_req_i       (d_read | d_write),
        .last_grant_i  (last_q),
        .grant_valid_o (grant_valid_s),
        .grant_src_o   (grant_src_s)
    );

    // State and latch registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC_I;
            src_q   <= SRC_I;
            op_q    <= OP_READ;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {LINE_W{1'b0}};
            line_q  <= {LINE_W{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
        end
    end

    // Next-state: requester inputs are only looked at in IDLE, pmem_resp only while busy.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    last_d = grant_src_s;
                    src_d  = grant_src_s;
                    if (grant_src_s == SRC_D) begin
                        addr_d  = d_address & ADDR_MASK;
                        wdata_d = d_wdata;
                        // Read and write together is resolved as a writeback.
                        op_d    = d_write ? OP_WRITE : OP_READ;
                        state_d = BUSY_D;
                    end else begin
                        addr_d  = i_address & ADDR_MASK;
                        op_d    = OP_READ;
                        state_d = BUSY_I;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    line_d  = pmem_rdata;
                    state_d = RESP;
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_s       = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign pmem_read    = busy_s && (op_q == OP_READ);
    assign pmem_write   = busy_s && (op_q == OP_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == RESP) && (src_q == SRC_I);
    assign d_resp  = (state_q == RESP) && (src_q == SRC_D);
    assign i_rdata = line_q;
    assign d_rdata = line_q;

endmodule
